// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf_pkg
// Brief   : Shared types, field polynomials and parameter checks for the
//           GF(2^M) inverse unit.
// Revision: 1.0
// ============================================================================
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gf_state_t;

    localparam logic [4:0] GF16_POLY  = 5'h13;
    localparam logic [8:0] GF256_POLY = 9'h11B;

    // True when poly is a degree-m polynomial with no factor of degree 1..m/2.
    function automatic bit gf_poly_ok(input int m, input logic [16:0] poly);
        logic [16:0] r;
        int          dd;
        if (m < 2 || m > 16) return 1'b0;
        if (!poly[m])        return 1'b0;
        if (!poly[0])        return 1'b0;
        for (int d = 2; d < (1 << (m / 2 + 1)); d++) begin
            dd = 0;
            for (int j = 0; j < 9; j++) begin
                if (d[j]) dd = j;
            end
            r = poly;
            for (int k = 16; k >= 1; k--) begin
                if (k >= dd && k <= m && r[k]) r = r ^ 17'(d << (k - dd));
            end
            if (r == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf_mult_m.sv
`default_nettype none
// ============================================================================
// Module  : gf_mult_m
// Brief   : Combinational polynomial-basis GF(2^M) multiply, reduced by POLY.
// Revision: 1.0
// ============================================================================
module gf_mult_m #(
    parameter int         M    = 4,
    parameter logic [M:0] POLY = 5'b10011
) (
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_p
);

    localparam int PW = 2 * M - 1;

    logic [PW-1:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < M; i++) begin
            if (i_b[i]) w_prod = w_prod ^ (PW'(i_a) << i);
        end
        // Clear high terms from the top down so each fold sees the final bit.
        for (int k = PW - 1; k >= M; k--) begin
            if (w_prod[k]) w_prod = w_prod ^ (PW'(POLY) << (k - M));
        end
    end

    assign o_p = w_prod[M-1:0];

endmodule
`default_nettype wire

// File: rtl/gf_inverse_iter.sv
`default_nettype none
// ============================================================================
// Module  : gf_inverse_iter
// Brief   : Iterative GF(2^M) inverse, a^(2^M-2) via square-and-multiply,
//           with valid/ready handshakes and a pass-through tag.
// Revision: 1.0
// ============================================================================
module gf_inverse_iter
    import gf_pkg::*;
#(
    parameter int         M     = 4,
    parameter logic [M:0] POLY  = 5'b10011,
    parameter int         TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam int               CNT_W    = (M < 2) ? 1 : $clog2(M);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 2);

    generate
        if (M < 2 || M > 16) begin : g_bad_width
            $error("gf_inverse_iter: M=%0d outside legal range 2..16", M);
        end else if (!gf_poly_ok(M, 17'(POLY))) begin : g_bad_poly
            $error("gf_inverse_iter: POLY is not an irreducible degree-%0d polynomial", M);
        end
    endgenerate

    gf_state_t        r_state;
    gf_state_t        w_next_state;
    logic [M-1:0]     r_sq;
    logic [M-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;
    logic [M-1:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_zero;
    logic [M-1:0]     w_sq2;
    logic [M-1:0]     w_acc_next;

    gf_mult_m #(.M(M), .POLY(POLY)) u_square (
        .i_a (r_sq),
        .i_b (r_sq),
        .o_p (w_sq2)
    );

    gf_mult_m #(.M(M), .POLY(POLY)) u_accum (
        .i_a (r_acc),
        .i_b (w_sq2),
        .o_p (w_acc_next)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)          w_next_state = CALC;
            CALC:    if (r_cnt == CNT_LAST) w_next_state = DONE;
            DONE:    if (out_ready)         w_next_state = IDLE;
            default:                        w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sq       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_zero     <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sq   <= in_data;
                        r_acc  <= M'(1);
                        r_cnt  <= '0;
                        r_tag  <= in_tag;
                        r_zero <= (in_data == '0);
                    end
                end
                CALC: begin
                    r_sq  <= w_sq2;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Result registers load once and then hold through DONE and IDLE.
                    if (r_cnt == CNT_LAST) begin
                        r_out_data <= w_acc_next;
                        r_out_tag  <= r_tag;
                        r_out_zero <= r_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_gf_inverse_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf_inverse_iter
// Brief   : Scoreboard bench for gf_inverse_iter at M=4 and M=8.
// Revision: 1.0
// ============================================================================
module tb_gf_inverse_iter;

    typedef struct {
        logic [3:0] d;
        logic [3:0] t;
        logic       z;
    } exp4_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        logic       z;
    } exp8_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v4 = 1'b0, or4 = 1'b1;
    logic [3:0] d4 = '0, t4 = '0;
    logic       rdy4, ov4, oz4;
    logic [3:0] od4, ot4;

    logic       v8 = 1'b0, or8 = 1'b1;
    logic [7:0] d8 = '0;
    logic [3:0] t8 = '0;
    logic       rdy8, ov8, oz8;
    logic [7:0] od8;
    logic [3:0] ot8;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc4  = 0;
    int n_ab4   = 0;
    int n_done4 = 0;
    bit rand_en = 1'b0;

    exp4_t q4[$];
    exp8_t q8[$];

    logic [3:0] inv_tbl [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                                 4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    always #5 clk = ~clk;

    gf_inverse_iter #(.M(4), .POLY(5'h13), .TAG_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .in_data   (d4),
        .in_tag    (t4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_data  (od4),
        .out_tag   (ot4),
        .out_zero  (oz4)
    );

    gf_inverse_iter #(.M(8), .POLY(9'h11B), .TAG_W(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_data   (d8),
        .in_tag    (t8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8),
        .out_tag   (ot8),
        .out_zero  (oz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the M=4 unit: ready must track the bench's own busy view.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready4", {31'b0, rdy4}, ((n_acc4 - n_ab4) != n_done4) ? 32'd0 : 32'd1);
            if (ov4 && or4) begin
                if (q4.size() == 0) begin
                    check("out4_spurious", {31'b0, ov4}, 32'd0);
                end else begin
                    exp4_t e;
                    e = q4.pop_front();
                    check("out4_data", {28'b0, od4}, {28'b0, e.d});
                    check("out4_tag",  {28'b0, ot4}, {28'b0, e.t});
                    check("out4_zero", {31'b0, oz4}, {31'b0, e.z});
                end
                n_done4++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                check("out8_spurious", {31'b0, ov8}, 32'd0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                check("out8_data", {24'b0, od8}, {24'b0, e.d});
                check("out8_tag",  {28'b0, ot8}, {28'b0, e.t});
                check("out8_zero", {31'b0, oz8}, {31'b0, e.z});
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_en) or4 = 1'($urandom_range(0, 1));
    end

    task automatic send4(input logic [3:0] d, input logic [3:0] t, input logic [3:0] e);
        int w = 0;
        @(negedge clk);
        while (!rdy4 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy4) begin
            check("send4_ready", {31'b0, rdy4}, 32'd1);
            return;
        end
        v4 = 1'b1;
        d4 = d;
        t4 = t;
        q4.push_back('{e, t, (d == 4'h0)});
        @(posedge clk);
        #1;
        v4 = 1'b0;
        n_acc4++;
    endtask

    task automatic send8(input logic [7:0] d, input logic [3:0] t, input logic [7:0] e);
        int w = 0;
        @(negedge clk);
        while (!rdy8 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy8) begin
            check("send8_ready", {31'b0, rdy8}, 32'd1);
            return;
        end
        v8 = 1'b1;
        d8 = d;
        t8 = t;
        q8.push_back('{e, t, (d == 8'h0)});
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    task automatic latency(input string name, input int exp_cyc, input bit is8);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(is8 ? ov8 : ov4) && cyc < 40);
        check(name, cyc, exp_cyc);
    endtask

    task automatic drain4(input string name);
        int w = 0;
        while (q4.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check(name, q4.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready",  {31'b0, rdy4}, 32'd1);
        check("rst_out_valid", {31'b0, ov4},  32'd0);
        check("rst_out_data",  {28'b0, od4},  32'd0);
        check("rst_out_tag",   {28'b0, ot4},  32'd0);
        check("rst_out_zero",  {31'b0, oz4},  32'd0);
        check("rst8_in_ready", {31'b0, rdy8}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed M=4 vectors with latency measurement.
        send4(4'h2, 4'h5, 4'h9);
        latency("lat4_first", 3, 1'b0);
        send4(4'h8, 4'h6, 4'hF);
        latency("lat4_second", 3, 1'b0);
        send4(4'h0, 4'h7, 4'h0);
        send4(4'h1, 4'h3, 4'h1);
        drain4("drain_directed");

        // Full sweep with random input gaps and random output backpressure.
        @(negedge clk);
        rand_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send4(i[3:0], 4'(15 - i), inv_tbl[i]);
        end
        drain4("drain_sweep");
        @(negedge clk);
        rand_en = 1'b0;
        @(posedge clk);
        #3 or4 = 1'b1;

        // Held result under backpressure; a new in_valid must be ignored.
        @(posedge clk);
        #2 or4 = 1'b0;
        send4(4'h7, 4'hA, 4'h6);
        begin
            int w = 0;
            while (!ov4 && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("bp_reach_done", {31'b0, ov4}, 32'd1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_data",     {28'b0, od4}, 32'h6);
            check("bp_tag",      {28'b0, ot4}, 32'hA);
            check("bp_valid",    {31'b0, ov4}, 32'd1);
            check("bp_in_ready", {31'b0, rdy4}, 32'd0);
            v4 = 1'b1;
            d4 = 4'h9;
        end
        @(posedge clk);
        #2;
        v4  = 1'b0;
        or4 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {31'b0, rdy4}, 32'd1);
        check("bp_release_valid", {31'b0, ov4},  32'd0);
        check("bp_hold_data",     {28'b0, od4},  32'h6);
        check("bp_hold_tag",      {28'b0, ot4},  32'hA);

        // Asynchronous reset one cycle into CALC abandons the operand.
        send4(4'h5, 4'h1, 4'hB);
        @(posedge clk);
        #2;
        rst = 1'b1;
        void'(q4.pop_back());
        n_ab4++;
        #1;
        check("arst_in_ready",  {31'b0, rdy4}, 32'd1);
        check("arst_out_valid", {31'b0, ov4},  32'd0);
        check("arst_out_data",  {28'b0, od4},  32'd0);
        check("arst_out_tag",   {28'b0, ot4},  32'd0);
        #4 rst = 1'b0;
        send4(4'h3, 4'h2, 4'hE);
        drain4("drain_after_reset");

        // M=8 AES field.
        send8(8'h53, 4'h9, 8'hCA);
        latency("lat8_first", 7, 1'b1);
        send8(8'h02, 4'h4, 8'h8D);
        latency("lat8_second", 7, 1'b1);
        repeat (4) @(posedge clk);
        check("drain8", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf_inverse_iter.md
Name: gf_inverse_iter

Overview:
Parametrised, iterative multiplicative-inverse unit over GF(2^M). The irreducible polynomial is chosen by parameter.
Computes a^(2^M-2) by repeated squaring and multiplication, and maps 0 to 0. Generalises the fixed 4-bit inverse lookup to any M from 2 to 16.
Sits in the S-box datapath between the affine/isomorphic mapping stages. Uses valid/ready handshakes on both sides and carries a sideband tag.

Parameters:
M, 4, field width in bits; legal range 2..16, elaboration error outside it
POLY, 5'b10011, irreducible polynomial, M+1 bits, MSB must be 1 (x^4+x+1); checked at elaboration
TAG_W, 4, width of sideband tag passed through unchanged

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  unit can accept operand
in_data  input  M  field element a
in_tag  input  TAG_W  sideband tag, captured with in_data
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  M  a^-1 (0 when a=0)
out_tag  output  TAG_W  tag captured with the operand
out_zero  output  1  operand was 0 (no true inverse)

Behaviour:
- Interface: one clock, clk. Asynchronous, active-high reset, rst. Reset acts immediately and does not wait for a clock edge.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_data = 0; out_tag = 0; out_zero = 0.
  - Internal sq, acc and cnt = 0.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only.
- IDLE: on an edge with in_valid && in_ready:
  - sq <= in_data; acc <= 1; cnt <= 0.
  - tag register <= in_tag; zero flag <= (in_data==0).
  - state -> CALC.
- CALC, per edge:
  - sq <= sq*sq mod POLY; acc <= acc*(sq*sq) mod POLY; cnt <= cnt+1.
  - When cnt == M-2 on that edge, state -> DONE.
  - Exactly M-1 iterations, so acc = product of a^(2^i) for i=1..M-1, which equals a^(2^M-2).
- Latency: operand accepted at edge k gives out_valid high after edge k+M-1 (k+3 for M=4). Throughput is one result per M+1 cycles minimum.
- DONE:
  - out_data, out_tag and out_zero are held stable while out_valid && !out_ready.
  - On an edge with out_ready: state -> IDLE. out_* keep their last values; only out_valid drops.
  - No new operand is accepted in the same cycle as the result handshake.
- Zero operand: the arithmetic naturally yields 0. out_zero = 1 and out_data = 0.
- Element 1 gives 1. The all-ones element is handled by the same datapath with no special casing.
- in_valid while busy: ignored, because in_ready = 0. The upstream block must hold it.
- Reset mid-CALC or mid-DONE: the result is abandoned, all registers take reset values, and out_valid is never asserted for that operand.
- Arithmetic: polynomial-basis, carry-less multiply of two M-bit values to a 2M-1 bit product, then reduction by POLY. No integer arithmetic. cnt is ceil(log2(M)) bits wide.

Decomposition:
- Shared package gf_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - constants GF16_POLY = 5'h13 and GF256_POLY = 9'h11B;
  - a constant function that checks irreducibility/MSB of POLY at elaboration.
- Sub-module gf_mult_m (parameters M and POLY) is a purely combinational multiply-and-reduce.
  - Instantiate it twice: one instance squares sq, the other multiplies acc by that square.
- The FSM, counter and handshake logic stay in gf_inverse_iter.

Test Plan:
- M=4, POLY=0x13, in_data=0x2, tag=0x5, out_ready=1 -> out_valid 3 cycles after accept, out_data=0x9, out_tag=0x5, out_zero=0. Then in_data=0x8 -> 0xF.
- M=4, in_data=0x0 -> out_data=0x0, out_zero=1. in_data=0x1 -> 0x1.
- M=4 exhaustive sweep of 0..15 with random in_valid/out_ready gaps -> matches 0,1,9,E,D,B,7,6,F,2,C,5,A,4,3,8. in_ready=0 throughout CALC/DONE. No lost or duplicated results.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_tag stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst asynchronously one cycle into CALC -> in_ready=1, out_valid=0, out_data=0 immediately. The next operand 0x3 returns 0xE normally.
- M=8, POLY=0x11B: in_data=0x53 -> out_data=0xCA after 7 cycles. in_data=0x02 -> 0x8D.
